// File: rtl/tmr_vote_stage.sv
// Two-stage triple-modular-redundancy voter with ready/valid handshake,
// per-replica fault tracking (OK/SUSPECT/DEGRADED/FATAL) and a saturating error counter.
module tmr_vote_stage #(
  parameter int WIDTH       = 2,
  parameter int CNT_W       = 8,
  parameter int DEAD_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic             err_sticky,
  output logic             fatal,
  output logic [2:0]       fault_mask,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W = (DEAD_THRESH < 2) ? 1 : $clog2(DEAD_THRESH + 1);
  localparam logic [RUN_W:0]   THRESH_V  = (RUN_W+1)'(DEAD_THRESH);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W:0]   RUN_ONE_X = (RUN_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_FATAL    = 2'd3
  } state_e;

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [1:0] first_set(input logic [2:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;
  logic             out_valid_q, err_q;
  logic [WIDTH-1:0] out_data_q;
  state_e           state_q;
  logic [1:0]       suspect_q;
  logic [RUN_W-1:0] run_q;
  logic [2:0]       fault_mask_q;
  logic [CNT_W-1:0] err_count_q;
  logic             err_sticky_q, fatal_q;

  logic             s2_take_s, adv_s, accept_s;
  logic [WIDTH-1:0] vote_d;
  logic             err_d, uncorr_s, multi_s;
  logic [2:0]       mis_s;
  logic [1:0]       mis_idx_s;
  logic [RUN_W:0]   run_inc_s;

  assign s2_take_s = !out_valid_q || out_ready;
  assign adv_s     = s1_valid_q && s2_take_s;
  assign in_ready  = !s1_valid_q || s2_take_s;
  assign accept_s  = in_valid && in_ready;
  assign run_inc_s = {1'b0, run_q} + RUN_ONE_X;

  // Vote over live replicas; with one replica dead the lower-index live one wins a tie-break.
  always_comb begin
    vote_d   = maj3(s1_a_q, s1_b_q, s1_c_q);
    uncorr_s = 1'b0;
    case (fault_mask_q)
      3'b001: begin
        vote_d   = s1_b_q;
        uncorr_s = (s1_b_q != s1_c_q);
      end
      3'b010: begin
        vote_d   = s1_a_q;
        uncorr_s = (s1_a_q != s1_c_q);
      end
      3'b100: begin
        vote_d   = s1_a_q;
        uncorr_s = (s1_a_q != s1_b_q);
      end
      default: begin
        vote_d   = maj3(s1_a_q, s1_b_q, s1_c_q);
        uncorr_s = 1'b0;
      end
    endcase
    mis_s[0]  = !fault_mask_q[0] && (s1_a_q != vote_d);
    mis_s[1]  = !fault_mask_q[1] && (s1_b_q != vote_d);
    mis_s[2]  = !fault_mask_q[2] && (s1_c_q != vote_d);
    multi_s   = (mis_s[0] & mis_s[1]) | (mis_s[0] & mis_s[2]) | (mis_s[1] & mis_s[2]);
    err_d     = (|mis_s) || uncorr_s;
    mis_idx_s = first_set(mis_s);
  end

  // Stage 1: capture replicas on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (accept_s) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
        s1_c_q <= in_c;
      end
    end
  end

  // Stage 2: voted result and its error flag, held while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (s2_take_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= vote_d;
        err_q      <= err_d;
      end
    end
  end

  // Error FSM and counters; evaluated only when a beat moves S1->S2, clr has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OK;
      suspect_q    <= 2'd0;
      run_q        <= '0;
      fault_mask_q <= 3'b000;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
      fatal_q      <= 1'b0;
    end else if (clr) begin
      state_q      <= ST_OK;
      suspect_q    <= 2'd0;
      run_q        <= '0;
      fault_mask_q <= 3'b000;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
      fatal_q      <= 1'b0;
    end else if (adv_s) begin
      if (err_d) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CNT_ONE;
      end
      if (multi_s || uncorr_s) begin
        state_q <= ST_FATAL;
        fatal_q <= 1'b1;
      end else begin
        case (state_q)
          ST_OK: begin
            if (mis_s != 3'b000) begin
              suspect_q <= mis_idx_s;
              run_q     <= RUN_ONE;
              if (RUN_ONE_X >= THRESH_V) begin
                state_q      <= ST_DEGRADED;
                fault_mask_q <= fault_mask_q | idx_onehot(mis_idx_s);
              end else begin
                state_q <= ST_SUSPECT;
              end
            end else begin
              state_q <= ST_OK;
              run_q   <= '0;
            end
          end
          ST_SUSPECT: begin
            if (mis_s == 3'b000) begin
              state_q <= ST_OK;
              run_q   <= '0;
            end else if (mis_idx_s == suspect_q) begin
              run_q <= run_inc_s[RUN_W-1:0];
              if (run_inc_s >= THRESH_V) begin
                state_q      <= ST_DEGRADED;
                fault_mask_q <= fault_mask_q | idx_onehot(mis_idx_s);
              end else begin
                state_q <= ST_SUSPECT;
              end
            end else begin
              state_q   <= ST_SUSPECT;
              suspect_q <= mis_idx_s;
              run_q     <= RUN_ONE;
            end
          end
          ST_DEGRADED: state_q <= ST_DEGRADED;
          ST_FATAL:    state_q <= ST_FATAL;
          default:     state_q <= ST_OK;
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign fatal      = fatal_q;
  assign fault_mask = fault_mask_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_tmr_vote_stage.sv
// Self-checking bench for tmr_vote_stage: directed scenarios plus randomized traffic
// checked against a replica-counting reference model.
module tb_tmr_vote_stage;
  localparam int WIDTH = 2;
  localparam int CNT_W = 8;
  localparam int DEAD_THRESH = 3;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid, in_ready, out_valid, out_ready, err, err_sticky, fatal;
  logic [WIDTH-1:0] in_a, in_b, in_c, out_data;
  logic [2:0] fault_mask;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [1:0] got_data[$], exp_data[$];
  bit         got_err[$], exp_err[$];

  // Reference model state: dead replica (-1 none), current mismatch run, flags.
  int md_dead, md_run_idx, md_run_len, md_count;
  bit md_fatal, md_sticky;

  always #5 clk = ~clk;

  tmr_vote_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEAD_THRESH(DEAD_THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_sticky(err_sticky), .fatal(fatal),
    .fault_mask(fault_mask), .err_count(err_count)
  );

  task automatic model_clear();
    md_dead = -1; md_run_idx = -1; md_run_len = 0; md_count = 0;
    md_fatal = 1'b0; md_sticky = 1'b0;
  endtask

  task automatic model_accept(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    logic [1:0] r[3];
    logic [1:0] v;
    int nmis, k, lo, hi, ones;
    bit unc, e;
    r[0] = a; r[1] = b; r[2] = c;
    unc = 1'b0; nmis = 0; k = -1; v = 2'b00;
    if (md_dead < 0) begin
      for (int bt = 0; bt < 2; bt++) begin
        ones = int'(r[0][bt]) + int'(r[1][bt]) + int'(r[2][bt]);
        v[bt] = (ones >= 2) ? 1'b1 : 1'b0;
      end
    end else begin
      lo = (md_dead == 0) ? 1 : 0;
      hi = (md_dead == 2) ? 1 : 2;
      v = r[lo];
      unc = (r[lo] != r[hi]);
    end
    for (int i = 0; i < 3; i++) begin
      if (i != md_dead && r[i] != v) begin nmis++; k = i; end
    end
    e = (nmis > 0) || unc;
    exp_data.push_back(v);
    exp_err.push_back(e);
    if (e) begin
      md_sticky = 1'b1;
      if (md_count < (1 << CNT_W) - 1) md_count++;
    end
    if (nmis >= 2 || unc) md_fatal = 1'b1;
    else if (md_fatal || md_dead >= 0) begin end
    else if (nmis == 0) begin md_run_idx = -1; md_run_len = 0; end
    else begin
      if (k == md_run_idx) md_run_len++;
      else begin md_run_idx = k; md_run_len = 1; end
      if (md_run_len >= DEAD_THRESH) begin md_dead = k; md_run_idx = -1; md_run_len = 0; end
    end
  endtask

  // One clock: observe handshakes on the falling edge, return #1 after the rising edge.
  task automatic cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) model_accept(in_a, in_b, in_c);
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_err.push_back(err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    got_data.delete(); got_err.delete(); exp_data.delete(); exp_err.delete();
  endtask

  task automatic pulse_clr();
    bit d;
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b1;
    cycle(d);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 2'b00; in_b = 2'b00; in_c = 2'b00;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL rst_out_data got=%b exp=00", out_data); end
    checks++; if ({err, err_sticky, fatal} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {err, err_sticky, fatal}); end
    checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL rst_fault_mask got=%b exp=000", fault_mask); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean();
    bit d;
    in_a = 2'b10; in_b = 2'b10; in_c = 2'b10; in_valid = 1'b1;
    cycle(d);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_early_valid got=%b exp=0", out_valid); end
    cycle(d);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency got=%b exp=1", out_valid); end
    checks++; if (out_data !== 2'b10) begin errors++; $display("FAIL clean_data got=%b exp=10", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clean_err got=%b exp=0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clean_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_degrade();
    bit d;
    pulse_clr();
    clear_queues();
    for (int i = 0; i < 3; i++) begin
      in_a = 2'b01; in_b = 2'b01; in_c = 2'b11; in_valid = 1'b1;
      cycle(d);
    end
    in_valid = 1'b0;
    repeat (3) cycle(d);
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL degrade_beats got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if ({got_data[i], got_err[i]} !== 3'b011) begin errors++; $display("FAIL degrade_beat%0d got=%b/%b exp=01/1", i, got_data[i], got_err[i]); end
    end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL degrade_count got=%0d exp=3", err_count); end
    checks++; if (fault_mask !== 3'b100) begin errors++; $display("FAIL degrade_mask got=%b exp=100", fault_mask); end
    checks++; if ({fatal, err_sticky} !== 2'b01) begin errors++; $display("FAIL degrade_flags got=%b exp=01", {fatal, err_sticky}); end
    clear_queues();
    in_a = 2'b01; in_b = 2'b01; in_c = 2'b00; in_valid = 1'b1;
    cycle(d);
    in_a = 2'b01; in_b = 2'b10; in_c = 2'b11;
    cycle(d);
    in_valid = 1'b0;
    repeat (3) cycle(d);
    checks++; if (got_data.size() != 2) begin errors++; $display("FAIL degrade_live_beats got=%0d exp=2", got_data.size()); end
    if (got_data.size() == 2) begin
      checks++; if ({got_data[0], got_err[0]} !== 3'b010) begin errors++; $display("FAIL degrade_live_agree got=%b/%b exp=01/0", got_data[0], got_err[0]); end
      checks++; if ({got_data[1], got_err[1]} !== 3'b011) begin errors++; $display("FAIL degrade_uncorr got=%b/%b exp=01/1", got_data[1], got_err[1]); end
    end
    checks++; if (fatal !== 1'b1) begin errors++; $display("FAIL degrade_to_fatal got=%b exp=1", fatal); end
  endtask

  task automatic test_fatal();
    bit d;
    pulse_clr();
    clear_queues();
    in_a = 2'b00; in_b = 2'b01; in_c = 2'b10; in_valid = 1'b1;
    cycle(d);
    in_valid = 1'b0;
    repeat (3) cycle(d);
    checks++; if (got_data.size() != 1) begin errors++; $display("FAIL fatal_beats got=%0d exp=1", got_data.size()); end
    if (got_data.size() == 1) begin
      checks++; if ({got_data[0], got_err[0]} !== 3'b001) begin errors++; $display("FAIL fatal_beat got=%b/%b exp=00/1", got_data[0], got_err[0]); end
    end
    checks++; if ({fatal, err_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL fatal_state got=%b/%0d exp=1/1", fatal, err_count); end
    pulse_clr();
    checks++; if ({fatal, err_sticky, fault_mask, err_count} !== 13'd0) begin errors++; $display("FAIL fatal_clr got=%b/%b/%b/%0d exp=0/0/000/0", fatal, err_sticky, fault_mask, err_count); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int idx, n;
    logic [1:0] vals[4];
    pulse_clr();
    clear_queues();
    for (int i = 0; i < 4; i++) vals[i] = 2'(i);
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_a = vals[idx]; in_b = vals[idx]; in_c = vals[idx]; end
      cycle(acc);
      if (acc) idx++;
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if ({out_valid, out_data} !== {1'b1, vals[0]}) begin errors++; $display("FAIL bp_hold got=%b/%b exp=1/%b", out_valid, out_data, vals[0]); end
    out_ready = 1'b1;
    n = 0;
    while (n < 20 && !(idx == 4 && got_data.size() == 4)) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_a = vals[idx]; in_b = vals[idx]; in_c = vals[idx]; end
      cycle(acc);
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++; if ({got_data[i], got_err[i]} !== {vals[i], 1'b0}) begin errors++; $display("FAIL bp_order%0d got=%b/%b exp=%b/0", i, got_data[i], got_err[i], vals[i]); end
    end
  endtask

  task automatic test_saturate();
    bit d;
    pulse_clr();
    in_a = 2'b00; in_b = 2'b01; in_c = 2'b10; in_valid = 1'b1;
    repeat (255) cycle(d);
    in_valid = 1'b0;
    repeat (3) cycle(d);
    checks++; if ({fatal, err_count} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_reach got=%b/%0d exp=1/255", fatal, err_count); end
    in_valid = 1'b1;
    cycle(d);
    in_valid = 1'b0;
    repeat (3) cycle(d);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", err_count); end
    in_valid = 1'b1;
    cycle(d);
    in_valid = 1'b0; clr = 1'b1;
    cycle(d);
    clr = 1'b0;
    checks++; if ({err_count, err_sticky, fatal} !== 10'd0) begin errors++; $display("FAIL sat_clr_wins got=%0d/%b/%b exp=0/0/0", err_count, err_sticky, fatal); end
    checks++; if ({out_valid, out_data, err} !== 4'b1001) begin errors++; $display("FAIL sat_clr_noflush got=%b/%b/%b exp=1/00/1", out_valid, out_data, err); end
    cycle(d);
  endtask

  task automatic test_random();
    bit acc;
    logic [1:0] v, a, b, c;
    int r, fav;
    logic [2:0] em;
    for (int ep = 0; ep < 4; ep++) begin
      pulse_clr();
      clear_queues();
      model_clear();
      fav = ep % 3;
      acc = 1'b0;
      for (int cy = 0; cy < 120; cy++) begin
        if (!in_valid || acc) begin
          v = 2'($urandom_range(0, 3));
          a = v; b = v; c = v;
          r = $urandom_range(0, 99);
          if (r < 30) begin
            if (fav == 0) a = v ^ 2'($urandom_range(1, 3));
            else if (fav == 1) b = v ^ 2'($urandom_range(1, 3));
            else c = v ^ 2'($urandom_range(1, 3));
          end else if (r < 36) begin
            a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3)); c = 2'($urandom_range(0, 3));
          end
          in_a = a; in_b = b; in_c = c;
          in_valid = ($urandom_range(0, 99) < 75);
        end
        out_ready = ($urandom_range(0, 99) < 70);
        cycle(acc);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) cycle(acc);
      checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", ep, got_data.size(), exp_data.size()); end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
        checks++; if ({got_data[i], got_err[i]} !== {exp_data[i], exp_err[i]}) begin errors++; $display("FAIL rnd%0d_beat%0d got=%b/%b exp=%b/%b", ep, i, got_data[i], got_err[i], exp_data[i], exp_err[i]); end
      end
      em = (md_dead < 0) ? 3'b000 : (3'b001 << md_dead);
      checks++; if (err_count !== 8'(md_count)) begin errors++; $display("FAIL rnd%0d_err_count got=%0d exp=%0d", ep, err_count, md_count); end
      checks++; if (fault_mask !== em) begin errors++; $display("FAIL rnd%0d_mask got=%b exp=%b", ep, fault_mask, em); end
      checks++; if ({fatal, err_sticky} !== {md_fatal, md_sticky}) begin errors++; $display("FAIL rnd%0d_flags got=%b%b exp=%b%b", ep, fatal, err_sticky, md_fatal, md_sticky); end
    end
  endtask

  task automatic test_reset_midflight();
    bit d;
    pulse_clr();
    out_ready = 1'b0;
    in_a = 2'b00; in_b = 2'b01; in_c = 2'b10; in_valid = 1'b1;
    repeat (3) cycle(d);
    in_valid = 1'b0;
    checks++; if ({out_valid, fatal} !== 2'b11) begin errors++; $display("FAIL mid_precond got=%b%b exp=11", out_valid, fatal); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_data, err} !== 4'b0000) begin errors++; $display("FAIL mid_async_out got=%b/%b/%b exp=0/00/0", out_valid, out_data, err); end
    checks++; if ({err_sticky, fatal, fault_mask, err_count} !== 13'd0) begin errors++; $display("FAIL mid_async_status got=%b/%b/%b/%0d exp=0/0/000/0", err_sticky, fatal, fault_mask, err_count); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    clear_queues();
    repeat (4) cycle(d);
    checks++; if (got_data.size() != 0) begin errors++; $display("FAIL mid_ghost_beats got=%0d exp=0", got_data.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean();
    test_degrade();
    test_fatal();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
